multi_queue_shared_fifo: RTL and testbench

Parametrised successor to the fixed two-queue FIFO: QUEUE_COUNT logical queues share one DEPTH-entry storage pool through per-queue linked lists and a free list. A per-queue occupancy cap stops one queue from starving the others. Sits between the packet classifier (single write stream tagged with a target queue) and the queue reader (one selectable read port, at most one pop per cycle).

---
 rtl/multi_queue_pkg.sv | 15 +
 rtl/multi_queue_free_list.sv | 57 +++++
 rtl/multi_queue_shared_fifo.sv | 150 +++++++++++++++
 tb/tb_multi_queue_shared_fifo.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_queue_pkg.sv
// multi_queue_pkg: shared helpers for the multi-queue shared FIFO
// and the queue reader that consumes its read port.
package multi_queue_pkg;

    // Index width that never collapses to zero bits.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Valid/ready transfer condition of a stream.
    function automatic logic fire(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/multi_queue_free_list.sv
// multi_queue_free_list: circular FIFO of unallocated slot indices.
// Starts full with 0..DEPTH-1; one alloc and one release per cycle.
module multi_queue_free_list
    import multi_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int SBITS = safe_clog2(DEPTH),
    localparam int CBITS = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_alloc,
    output logic [SBITS-1:0] o_alloc_idx,
    input  logic             i_release,
    input  logic [SBITS-1:0] i_release_idx,
    output logic [CBITS-1:0] o_count
);

    logic [SBITS-1:0] r_idx [DEPTH];
    logic [SBITS-1:0] r_rd;
    logic [SBITS-1:0] r_wr;
    logic [CBITS-1:0] r_count;

    function automatic logic [SBITS-1:0] nxt(input logic [SBITS-1:0] p);
        return (p == SBITS'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_alloc_idx = r_idx[r_rd];
    assign o_count     = r_count;

    // Index ring: reset refills it in ascending order; a released slot
    // lands at the tail and is only visible to alloc from the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_idx[i] <= SBITS'(i);
            end
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= CBITS'(DEPTH);
        end else begin
            if (i_release) begin
                r_idx[r_wr] <= i_release_idx;
                r_wr        <= nxt(r_wr);
            end
            if (i_alloc) begin
                r_rd <= nxt(r_rd);
            end
            if (i_alloc && !i_release) begin
                r_count <= r_count - 1'b1;
            end else if (!i_alloc && i_release) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_queue_shared_fifo.sv
// multi_queue_shared_fifo: QUEUE_COUNT linked-list queues sharing a
// DEPTH-entry pool, with a per-queue occupancy cap.
module multi_queue_shared_fifo
    import multi_queue_pkg::*;
#(
    parameter int QUEUE_COUNT = 4,
    parameter int DEPTH       = 16,
    parameter int WIDTH       = 32,
    parameter int QUEUE_LIMIT = DEPTH,
    localparam int QBITS = safe_clog2(QUEUE_COUNT),
    localparam int SBITS = safe_clog2(DEPTH),
    localparam int LBITS = $clog2(QUEUE_LIMIT + 1),
    localparam int FBITS = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [QBITS-1:0]             in_target,
    input  logic [WIDTH-1:0]             in_payload,
    output logic [QUEUE_COUNT-1:0]       in_ready,
    input  logic [QBITS-1:0]             out_select,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_payload,
    input  logic                         out_ready,
    output logic [QUEUE_COUNT*LBITS-1:0] level,
    output logic [FBITS-1:0]             free_level
);

    typedef logic [QBITS-1:0] queue_id_t;
    typedef logic [SBITS-1:0] slot_t;
    typedef logic [LBITS-1:0] level_t;

    logic [WIDTH-1:0] r_data  [DEPTH];
    slot_t            r_next  [DEPTH];
    slot_t            r_head  [QUEUE_COUNT];
    slot_t            r_tail  [QUEUE_COUNT];
    level_t           r_level [QUEUE_COUNT];

    logic [FBITS-1:0]       w_free_cnt;
    slot_t                  w_alloc_slot;
    slot_t                  w_sel_head;
    level_t                 w_sel_level;
    level_t                 w_tgt_level;
    logic                   w_tgt_ok;
    logic                   w_sel_ok;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_push_empty;
    logic                   w_out_valid;
    logic [QUEUE_COUNT-1:0] w_push_q;
    logic [QUEUE_COUNT-1:0] w_pop_q;

    assign w_tgt_ok    = 32'(in_target) < QUEUE_COUNT;
    assign w_sel_ok    = 32'(out_select) < QUEUE_COUNT;
    assign w_tgt_level = r_level[in_target];
    assign w_sel_level = r_level[out_select];
    assign w_sel_head  = r_head[out_select];

    // Acceptance depends on registered counts only, never on the read side.
    always_comb begin
        in_ready = '0;
        for (int q = 0; q < QUEUE_COUNT; q++) begin
            in_ready[q] = !rst && (w_free_cnt != '0) &&
                          (r_level[q] < level_t'(QUEUE_LIMIT));
        end
    end

    assign w_push      = fire(in_valid, w_tgt_ok && in_ready[in_target]);
    assign w_out_valid = w_sel_ok && (w_sel_level != '0);
    assign w_pop       = fire(w_out_valid, out_ready);
    assign out_valid   = w_out_valid;
    assign out_payload = w_out_valid ? r_data[w_sel_head] : '0;

    // A push into a queue that is, or is being drained to, empty starts a
    // fresh list instead of linking behind the stale tail.
    assign w_push_empty = (w_tgt_level == '0) ||
                          ((w_tgt_level == level_t'(1)) && w_pop &&
                           (out_select == in_target));

    // Per-queue push/pop strobes.
    always_comb begin
        w_push_q = '0;
        w_pop_q  = '0;
        for (int q = 0; q < QUEUE_COUNT; q++) begin
            w_push_q[q] = w_push && (in_target == queue_id_t'(q));
            w_pop_q[q]  = w_pop && (out_select == queue_id_t'(q));
        end
    end

    multi_queue_free_list #(
        .DEPTH (DEPTH)
    ) u_free_list (
        .clk           (clk),
        .rst           (rst),
        .i_alloc       (w_push),
        .o_alloc_idx   (w_alloc_slot),
        .i_release     (w_pop),
        .i_release_idx (w_sel_head),
        .o_count       (w_free_cnt)
    );

    // Payload and link storage; contents are meaningless until linked.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[w_alloc_slot] <= in_payload;
            if (!w_push_empty) begin
                r_next[r_tail[in_target]] <= w_alloc_slot;
            end
        end
    end

    // Head/tail pointers and occupancy per queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int q = 0; q < QUEUE_COUNT; q++) begin
                r_head[q]  <= '0;
                r_tail[q]  <= '0;
                r_level[q] <= '0;
            end
        end else begin
            for (int q = 0; q < QUEUE_COUNT; q++) begin
                if (w_pop_q[q]) begin
                    r_head[q] <= r_next[r_head[q]];
                end
                if (w_push_q[q]) begin
                    r_tail[q] <= w_alloc_slot;
                    if (w_push_empty) begin
                        r_head[q] <= w_alloc_slot;
                    end
                end
                if (w_push_q[q] && !w_pop_q[q]) begin
                    r_level[q] <= r_level[q] + 1'b1;
                end else if (!w_push_q[q] && w_pop_q[q]) begin
                    r_level[q] <= r_level[q] - 1'b1;
                end
            end
        end
    end

    // Flatten per-queue occupancy onto the level bus.
    always_comb begin
        level = '0;
        for (int q = 0; q < QUEUE_COUNT; q++) begin
            level[q*LBITS +: LBITS] = r_level[q];
        end
    end

    assign free_level = w_free_cnt;

endmodule

// File: tb/tb_multi_queue_shared_fifo.sv
// tb_multi_queue_shared_fifo: directed scenarios against hand-computed
// expectations, 4 queues, 16 entries, cap of 4 per queue.
module tb_multi_queue_shared_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_target = '0;
    logic [31:0] in_payload = '0;
    logic [3:0]  in_ready;
    logic [1:0]  out_select = '0;
    logic        out_valid;
    logic [31:0] out_payload;
    logic        out_ready = 1'b0;
    logic [11:0] level;
    logic [4:0]  free_level;

    int checks = 0;
    int errors = 0;

    multi_queue_shared_fifo #(
        .QUEUE_COUNT (4),
        .DEPTH       (16),
        .WIDTH       (32),
        .QUEUE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_target   (in_target),
        .in_payload  (in_payload),
        .in_ready    (in_ready),
        .out_select  (out_select),
        .out_valid   (out_valid),
        .out_payload (out_payload),
        .out_ready   (out_ready),
        .level       (level),
        .free_level  (free_level)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] lv(input int q);
        return level[q*3 +: 3];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int q, input logic [31:0] d);
        in_valid   = 1'b1;
        in_target  = 2'(q);
        in_payload = d;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        checks++; if (out_payload !== 32'h0) begin errors++; $display("FAIL rst_payload got=%h exp=0", out_payload); end
        checks++; if (level !== 12'h0) begin errors++; $display("FAIL rst_level got=%h exp=0", level); end
        checks++; if (free_level !== 5'd16) begin errors++; $display("FAIL rst_free got=%0d exp=16", free_level); end
        checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL rst_ready got=%b exp=0000", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL rel_ready got=%b exp=1111", in_ready); end
        tick();
    endtask

    task automatic test_single_queue();
        for (int i = 0; i < 4; i++) push(2, 32'(32'hA0 + i));
        #1;
        checks++; if (lv(2) !== 3'd4) begin errors++; $display("FAIL q2_level got=%0d exp=4", lv(2)); end
        checks++; if (free_level !== 5'd12) begin errors++; $display("FAIL q2_free got=%0d exp=12", free_level); end
        checks++; if (in_ready !== 4'b1011) begin errors++; $display("FAIL q2_ready got=%b exp=1011", in_ready); end
        out_select = 2'd2;
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL q2_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_payload !== 32'(32'hA0 + i)) begin errors++; $display("FAIL q2_data[%0d] got=%h exp=%h", i, out_payload, 32'hA0 + i); end
            tick();
        end
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL q2_empty got=%b exp=0", out_valid); end
        checks++; if (out_payload !== 32'h0) begin errors++; $display("FAIL q2_mask got=%h exp=0", out_payload); end
        checks++; if (lv(2) !== 3'd0) begin errors++; $display("FAIL q2_level_end got=%0d exp=0", lv(2)); end
        checks++; if (free_level !== 5'd16) begin errors++; $display("FAIL q2_free_end got=%0d exp=16", free_level); end
    endtask

    task automatic test_interleave();
        logic [31:0] exp1 [2];
        logic [31:0] exp0 [2];
        exp1 = '{32'h20, 32'h21};
        exp0 = '{32'h10, 32'h11};
        push(0, 32'h10);
        push(1, 32'h20);
        push(0, 32'h11);
        push(1, 32'h21);
        out_ready  = 1'b1;
        out_select = 2'd1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (out_payload !== exp1[i]) begin errors++; $display("FAIL il_q1[%0d] got=%h exp=%h", i, out_payload, exp1[i]); end
            tick();
        end
        out_select = 2'd0;
        #1;
        checks++; if (lv(1) !== 3'd0) begin errors++; $display("FAIL il_q1_level got=%0d exp=0", lv(1)); end
        checks++; if (lv(0) !== 3'd2) begin errors++; $display("FAIL il_q0_level got=%0d exp=2", lv(0)); end
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (out_payload !== exp0[i]) begin errors++; $display("FAIL il_q0[%0d] got=%h exp=%h", i, out_payload, exp0[i]); end
            tick();
        end
        out_ready = 1'b0;
        #1;
        checks++; if (free_level !== 5'd16) begin errors++; $display("FAIL il_free got=%0d exp=16", free_level); end
    endtask

    task automatic test_queue_cap();
        in_valid  = 1'b1;
        in_target = 2'd3;
        for (int i = 0; i < 5; i++) begin
            in_payload = 32'(32'h30 + i);
            #1;
            checks++; if (in_ready[3] !== (i < 4)) begin errors++; $display("FAIL cap_ready3[%0d] got=%b exp=%b", i, in_ready[3], i < 4); end
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (lv(3) !== 3'd4) begin errors++; $display("FAIL cap_level got=%0d exp=4", lv(3)); end
        checks++; if (free_level !== 5'd12) begin errors++; $display("FAIL cap_free got=%0d exp=12", free_level); end
        checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL cap_ready0 got=%b exp=1", in_ready[0]); end
        out_select = 2'd3;
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out_payload !== 32'(32'h30 + i)) begin errors++; $display("FAIL cap_data[%0d] got=%h exp=%h", i, out_payload, 32'h30 + i); end
            tick();
        end
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cap_extra got=%b exp=0", out_valid); end
    endtask

    task automatic test_pool_full();
        logic [31:0] exp;
        for (int q = 0; q < 4; q++) begin
            for (int i = 0; i < 4; i++) push(q, 32'(32'h40 + 16 * q + i));
        end
        #1;
        checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL full_ready got=%b exp=0000", in_ready); end
        checks++; if (free_level !== 5'd0) begin errors++; $display("FAIL full_free got=%0d exp=0", free_level); end
        in_valid   = 1'b1;
        in_target  = 2'd0;
        in_payload = 32'hEE;
        out_select = 2'd0;
        out_ready  = 1'b1;
        #1;
        checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL popcyc_ready got=%b exp=0000", in_ready); end
        checks++; if (out_payload !== 32'h40) begin errors++; $display("FAIL popcyc_data got=%h exp=40", out_payload); end
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL after_pop_ready got=%b exp=0001", in_ready); end
        checks++; if (free_level !== 5'd1) begin errors++; $display("FAIL after_pop_free got=%0d exp=1", free_level); end
        checks++; if (lv(0) !== 3'd3) begin errors++; $display("FAIL after_pop_level got=%0d exp=3", lv(0)); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (free_level !== 5'd0) begin errors++; $display("FAIL refill_free got=%0d exp=0", free_level); end
        checks++; if (lv(0) !== 3'd4) begin errors++; $display("FAIL refill_level got=%0d exp=4", lv(0)); end
        out_ready = 1'b1;
        for (int q = 0; q < 4; q++) begin
            out_select = 2'(q);
            for (int i = 0; i < 4; i++) begin
                if (q == 0) exp = (i < 3) ? 32'(32'h41 + i) : 32'hEE;
                else        exp = 32'(32'h40 + 16 * q + i);
                #1;
                checks++; if (out_payload !== exp) begin errors++; $display("FAIL full_drain q%0d[%0d] got=%h exp=%h", q, i, out_payload, exp); end
                tick();
            end
        end
        out_ready = 1'b0;
        #1;
        checks++; if (free_level !== 5'd16) begin errors++; $display("FAIL full_drain_free got=%0d exp=16", free_level); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        push(1, 32'h55);
        out_select = 2'd1;
        for (int k = 0; k < 100; k++) begin
            in_valid   = 1'b1;
            in_target  = 2'd1;
            in_payload = 32'(32'h66 + k);
            out_ready  = 1'b1;
            exp = (k == 0) ? 32'h55 : 32'(32'h66 + k - 1);
            #1;
            checks++; if (out_payload !== exp) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, out_payload, exp); end
            tick();
            checks++; if (lv(1) !== 3'd1) begin errors++; $display("FAIL b2b_level[%0d] got=%0d exp=1", k, lv(1)); end
            checks++; if (free_level !== 5'd15) begin errors++; $display("FAIL b2b_free[%0d] got=%0d exp=15", k, free_level); end
        end
        in_valid = 1'b0;
        #1;
        checks++; if (out_payload !== 32'(32'h66 + 99)) begin errors++; $display("FAIL b2b_last got=%h exp=%h", out_payload, 32'h66 + 99); end
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (lv(1) !== 3'd0) begin errors++; $display("FAIL b2b_level_end got=%0d exp=0", lv(1)); end
        checks++; if (free_level !== 5'd16) begin errors++; $display("FAIL b2b_free_end got=%0d exp=16", free_level); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) push(0, 32'(32'hC0 + i));
        for (int i = 0; i < 2; i++) push(1, 32'(32'hD0 + i));
        for (int i = 0; i < 2; i++) push(2, 32'(32'hE0 + i));
        out_select = 2'd0;
        #1;
        checks++; if (free_level !== 5'd9) begin errors++; $display("FAIL mid_pre_free got=%0d exp=9", free_level); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        checks++; if (level !== 12'h0) begin errors++; $display("FAIL mid_level got=%h exp=0", level); end
        checks++; if (free_level !== 5'd16) begin errors++; $display("FAIL mid_free got=%0d exp=16", free_level); end
        checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL mid_ready got=%b exp=0000", in_ready); end
        tick();
        rst        = 1'b0;
        in_valid   = 1'b1;
        in_target  = 2'd0;
        in_payload = 32'h77;
        #1;
        checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL mid_rel_ready got=%b exp=1111", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_rd_valid got=%b exp=1", out_valid); end
        checks++; if (out_payload !== 32'h77) begin errors++; $display("FAIL mid_rd_data got=%h exp=77", out_payload); end
        checks++; if (lv(0) !== 3'd1) begin errors++; $display("FAIL mid_rd_level got=%0d exp=1", lv(0)); end
        checks++; if (free_level !== 5'd15) begin errors++; $display("FAIL mid_rd_free got=%0d exp=15", free_level); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (free_level !== 5'd16) begin errors++; $display("FAIL mid_end_free got=%0d exp=16", free_level); end
    endtask

    initial begin
        test_reset();
        test_single_queue();
        test_interleave();
        test_queue_cap();
        test_pool_full();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
